// File: rtl/mat_mul_ab_if.sv
// mat_mul_ab_if: handshake, source-BRAM read ports and C readback bus of
// the matrix-product stage. The slave side is the product engine; the
// master side is its surroundings (A/B BRAMs, ready flags, C consumer).
interface mat_mul_ab_if;
  logic        a_ready;
  logic        b_ready;
  logic [7:0]  addrbA;
  logic [31:0] doutbA;
  logic [7:0]  addrbB;
  logic [31:0] doutbB;
  logic [7:0]  addrC;
  logic [31:0] doutC;
  logic        busy;
  logic        mul_done;
  logic [31:0] csum;

  modport master (
    output a_ready, b_ready, doutbA, doutbB, addrC,
    input  addrbA, addrbB, doutC, busy, mul_done, csum
  );

  modport slave (
    input  a_ready, b_ready, doutbA, doutbB, addrC,
    output addrbA, addrbB, doutC, busy, mul_done, csum
  );
endinterface

// File: rtl/mat_mul_ab.sv
// mat_mul_ab: computes C = A*B (mod 2^32) from two registered-read BRAMs
// once both report their writes complete, stores C internally and offers
// a registered readback port. A is row-major, B is column-major, so one
// dot product walks both address streams with the same k step.
// Optional feature: define MATMUL_CHECKSUM_EN to keep an XOR checksum of
// every C entry written during a run on csum; otherwise csum is tied to 0.
module mat_mul_ab #(
  parameter int N      = 2,
  parameter int P      = 4,
  parameter int M      = 3,
  parameter int A_BASE = 0,
  parameter int B_BASE = 1
) (
  input  logic          clk,
  input  logic          reset,
  mat_mul_ab_if.slave   bus
);

  localparam int         NM     = N * M;
  localparam int         CW     = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [7:0] LAST_I = 8'(N - 1);
  localparam logic [7:0] LAST_J = 8'(M - 1);
  localparam logic [7:0] LAST_K = 8'(P - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LAST, DONE} state_t;

  state_t      state_q;
  logic [7:0]  iCnt_q;
  logic [7:0]  jCnt_q;
  logic [7:0]  kCnt_q;
  logic [31:0] acc_q;
  logic        busy_q;
  logic        done_q;
  logic [7:0]  addrA_q;
  logic [7:0]  addrB_q;
  logic [31:0] cMem_q [NM];
  logic [31:0] doutC_q;

  logic [7:0]    addrACalc;
  logic [7:0]    addrBCalc;
  logic [31:0]   prod;
  logic [31:0]   accNext_d;
  logic [CW-1:0] wrIdx;
  logic [CW-1:0] rdIdx;
  logic          rdInRange;
  logic          bothReady;

  assign bothReady = bus.a_ready & bus.b_ready;
  assign addrACalc = 8'(A_BASE + int'(iCnt_q) * P + int'(kCnt_q));
  assign addrBCalc = 8'(B_BASE + int'(jCnt_q) * P + int'(kCnt_q));
  assign prod      = bus.doutbA * bus.doutbB;
  assign accNext_d = acc_q + prod;
  assign wrIdx     = CW'(int'(iCnt_q) * M + int'(jCnt_q));
  assign rdIdx     = CW'(bus.addrC);
  assign rdInRange = ({24'd0, bus.addrC} < 32'(NM));

  // Addresses follow the counters while fetching and freeze on the last
  // fetched address otherwise, so the BRAMs see a quiet bus between runs.
  assign bus.addrbA   = (state_q == FETCH) ? addrACalc : addrA_q;
  assign bus.addrbB   = (state_q == FETCH) ? addrBCalc : addrB_q;
  assign bus.busy     = busy_q;
  assign bus.mul_done = done_q;
  assign bus.doutC    = doutC_q;

  // Sequencer: walks (i, j, k), accumulates one dot product per C entry and
  // writes it in LAST, where the final operand pair arrives from the BRAMs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      iCnt_q  <= '0;
      jCnt_q  <= '0;
      kCnt_q  <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addrA_q <= 8'(A_BASE);
      addrB_q <= 8'(B_BASE);
      for (int n = 0; n < NM; n++) cMem_q[n] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bothReady) begin
            iCnt_q  <= '0;
            jCnt_q  <= '0;
            kCnt_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= FETCH;
          end
        end
        FETCH: begin
          addrA_q <= addrACalc;
          addrB_q <= addrBCalc;
          if (kCnt_q == '0) acc_q <= '0;
          else              acc_q <= accNext_d;
          if (kCnt_q == LAST_K) state_q <= LAST;
          else                  kCnt_q  <= kCnt_q + 8'd1;
        end
        LAST: begin
          cMem_q[wrIdx] <= accNext_d;
          kCnt_q        <= '0;
          state_q       <= FETCH;
          if (jCnt_q == LAST_J) begin
            jCnt_q <= '0;
            if (iCnt_q == LAST_I) begin
              iCnt_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              iCnt_q <= iCnt_q + 8'd1;
            end
          end else begin
            jCnt_q <= jCnt_q + 8'd1;
          end
        end
        DONE: begin
          if (!bothReady) begin
            done_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered readback of C; addresses past the last entry read as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) doutC_q <= '0;
    else        doutC_q <= rdInRange ? cMem_q[rdIdx] : '0;
  end

`ifdef MATMUL_CHECKSUM_EN
  logic [31:0] csum_q;

  // Running XOR of every C entry written in the current run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          csum_q <= '0;
    else if (state_q == IDLE && bothReady) csum_q <= '0;
    else if (state_q == LAST)            csum_q <= csum_q ^ accNext_d;
  end

  assign bus.csum = csum_q;
`else
  assign bus.csum = '0;
`endif

endmodule

// File: tb/tb_mat_mul_ab.sv
// tb_mat_mul_ab: directed sequence of runs with constant and random
// matrices, checked against a plain-arithmetic matrix product.
module tb_mat_mul_ab;

  localparam int N      = 2;
  localparam int P      = 4;
  localparam int M      = 3;
  localparam int A_BASE = 0;
  localparam int B_BASE = 1;
  localparam int NM     = N * M;
  localparam int RUN_CYCLES = N * M * (P + 1);

  logic clk;
  logic reset;

  mat_mul_ab_if ifc ();

  mat_mul_ab #(
    .N(N), .P(P), .M(M), .A_BASE(A_BASE), .B_BASE(B_BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] matA [N][P];
  logic [31:0] matB [P][M];
  logic [31:0] expC [NM];
  logic [31:0] expCsum;
  logic [31:0] memA [256];
  logic [31:0] memB [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read BRAM models for the A and B sources.
  always @(posedge clk) begin
    ifc.doutbA <= memA[ifc.addrbA];
    ifc.doutbB <= memB[ifc.addrbB];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] expv);
    testsRun++;
    assert (obs === expv) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic aRdy, input logic bRdy);
    @(negedge clk);
    ifc.a_ready = aRdy;
    ifc.b_ready = bRdy;
  endtask

  // Lay the matrices out in the BRAMs and compute the expected product.
  task automatic loadMatrices();
    logic [31:0] sum;
    for (int n = 0; n < 256; n++) begin
      memA[n] = '0;
      memB[n] = '0;
    end
    for (int i = 0; i < N; i++)
      for (int k = 0; k < P; k++) memA[A_BASE + i*P + k] = matA[i][k];
    for (int k = 0; k < P; k++)
      for (int j = 0; j < M; j++) memB[B_BASE + j*P + k] = matB[k][j];
    expCsum = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < M; j++) begin
        sum = '0;
        for (int k = 0; k < P; k++) sum = sum + matA[i][k] * matB[k][j];
        expC[i*M + j] = sum;
        expCsum = expCsum ^ sum;
      end
`ifndef MATMUL_CHECKSUM_EN
    expCsum = '0;
`endif
  endtask

  task automatic fillRandom();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < P; k++) matA[i][k] = $urandom;
    for (int k = 0; k < P; k++)
      for (int j = 0; j < M; j++) matB[k][j] = $urandom;
  endtask

  task automatic readC(input logic [7:0] addr, output logic [31:0] data);
    @(negedge clk);
    ifc.addrC = addr;
    @(negedge clk);
    data = ifc.doutC;
  endtask

  task automatic checkReadback(input string tag);
    logic [31:0] d;
    for (int n = 0; n < NM; n++) begin
      readC(8'(n), d);
      checkOutput($sformatf("%s_C%0d", tag, n), d, expC[n]);
    end
    readC(8'(NM), d);
    checkOutput({tag, "_oob"}, d, 32'd0);
  endtask

  // Counts busy cycles of a run started at the previous negedge; bounded.
  task automatic runMeasure(input int dropAt, output int busyCycles,
                            output logic firstBusy);
    busyCycles = 0;
    firstBusy  = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (c == 0) firstBusy = ifc.busy;
      if (ifc.busy) begin
        busyCycles++;
        if (busyCycles == dropAt) ifc.a_ready = 1'b0;
      end else if (busyCycles > 0) begin
        break;
      end
    end
  endtask

  task automatic checkRun(input string tag, input int dropAt);
    int   cyc;
    logic fb;
    runMeasure(dropAt, cyc, fb);
    checkOutput({tag, "_busyRise"}, {31'd0, fb}, 32'd1);
    checkOutput({tag, "_busyLen"}, 32'(cyc), 32'(RUN_CYCLES));
    checkOutput({tag, "_doneRise"}, {31'd0, ifc.mul_done}, 32'd1);
    checkOutput({tag, "_csum"}, ifc.csum, expCsum);
    checkOutput({tag, "_addrAHold"}, {24'd0, ifc.addrbA},
                32'(A_BASE + (N-1)*P + P-1));
    checkOutput({tag, "_addrBHold"}, {24'd0, ifc.addrbB},
                32'(B_BASE + (M-1)*P + P-1));
  endtask

  initial begin
    logic sawBusy;
    logic [31:0] d;

    reset = 1'b0;
    ifc.a_ready = 1'b0;
    ifc.b_ready = 1'b0;
    ifc.addrC   = '0;
    for (int n = 0; n < NM; n++) expC[n] = '0;
    expCsum = '0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", {31'd0, ifc.busy}, 32'd0);
    checkOutput("rst_done", {31'd0, ifc.mul_done}, 32'd0);
    checkOutput("rst_doutC", ifc.doutC, 32'd0);
    checkOutput("rst_csum", ifc.csum, 32'd0);
    checkOutput("rst_addrA", {24'd0, ifc.addrbA}, 32'(A_BASE));
    checkOutput("rst_addrB", {24'd0, ifc.addrbB}, 32'(B_BASE));
    reset = 1'b1;
    checkReadback("rstC");

    // Run 1: A all ones, B column j holds j+1
    for (int i = 0; i < N; i++)
      for (int k = 0; k < P; k++) matA[i][k] = 32'd1;
    for (int k = 0; k < P; k++)
      for (int j = 0; j < M; j++) matB[k][j] = 32'(j + 1);
    loadMatrices();
    applyStimulus(1'b1, 1'b1);
    checkRun("ones", -1);
    checkReadback("ones");
    readC(8'd2, d);
    checkOutput("ones_C02_const", d, 32'd12);
    checkOutput("ones_doneHold", {31'd0, ifc.mul_done}, 32'd1);
    applyStimulus(1'b0, 1'b1);
    @(negedge clk);
    checkOutput("ones_doneFall", {31'd0, ifc.mul_done}, 32'd0);

    // Run 2: wraparound, every entry 4*(0xFFFFFFFF*2) mod 2^32
    for (int i = 0; i < N; i++)
      for (int k = 0; k < P; k++) matA[i][k] = 32'hFFFF_FFFF;
    for (int k = 0; k < P; k++)
      for (int j = 0; j < M; j++) matB[k][j] = 32'd2;
    loadMatrices();
    applyStimulus(1'b1, 1'b1);
    checkRun("wrap", -1);
    readC(8'd5, d);
    checkOutput("wrap_C12_const", d, 32'hFFFF_FFF8);
    checkReadback("wrap");
    applyStimulus(1'b0, 1'b0);

    // Run 3: staggered readies, a_ready dropped mid-run
    fillRandom();
    loadMatrices();
    applyStimulus(1'b1, 1'b0);
    sawBusy = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ifc.busy) sawBusy = 1'b1;
    end
    checkOutput("stag_noEarlyBusy", {31'd0, sawBusy}, 32'd0);
    applyStimulus(1'b1, 1'b1);
    checkRun("stag", 12);
    @(negedge clk);
    checkOutput("stag_doneFall", {31'd0, ifc.mul_done}, 32'd0);
    checkReadback("stag");
    applyStimulus(1'b0, 1'b0);

    // Run 4: asynchronous reset in the middle of a run, then a fresh run
    fillRandom();
    loadMatrices();
    applyStimulus(1'b1, 1'b1);
    repeat (15) @(negedge clk);
    checkOutput("midrst_preBusy", {31'd0, ifc.busy}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", {31'd0, ifc.busy}, 32'd0);
    checkOutput("midrst_done", {31'd0, ifc.mul_done}, 32'd0);
    checkOutput("midrst_addrA", {24'd0, ifc.addrbA}, 32'(A_BASE));
    ifc.a_ready = 1'b0;
    ifc.b_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < NM; n++) begin
      readC(8'(n), d);
      checkOutput($sformatf("midrst_zeroC%0d", n), d, 32'd0);
    end
    applyStimulus(1'b1, 1'b1);
    checkRun("fresh", -1);
    checkReadback("fresh");
    applyStimulus(1'b0, 1'b0);

    // Run 5: one more random pair
    fillRandom();
    loadMatrices();
    applyStimulus(1'b1, 1'b1);
    checkRun("rand", -1);
    checkReadback("rand");
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("rand_doneFall", {31'd0, ifc.mul_done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
